// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between two pipeline stages and the stage register sitting between them.
// slave: the stage register side; master: the surrounding pipeline side.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 160
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: optional two-entry skid buffer, flush-to-NOP,
// and saturating stall/bubble/flush counters.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W  = 160,
  parameter logic [DATA_W-1:0] CLR_VAL = {DATA_W{1'b0}},
  parameter bit                SKID    = 1'b1,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  pipe_stage_reg_if.slave   bus,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              valid_q, valid_d;
  logic              in_ready_c;
  logic              in_fire_c;
  logic              out_fire_c;

  // With SKID the ready is a pure flop decode; without it, ready passes through from downstream.
  always_comb begin
    if (SKID) in_ready_c = (state_q != ST_TWO);
    else      in_ready_c = !valid_q || bus.out_ready;
  end

  assign in_fire_c     = bus.in_valid && in_ready_c;
  assign out_fire_c    = valid_q && bus.out_ready;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = main_q;

  // Next-state and datapath; skid only ever drains into main, keeping FIFO order.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire_c) begin
          state_d = ST_ONE;
          main_d  = bus.in_data;
        end
      end
      ST_ONE: begin
        if (in_fire_c && out_fire_c) begin
          main_d = bus.in_data;
        end else if (in_fire_c && !bus.out_ready) begin
          if (SKID) begin
            state_d = ST_TWO;
            skid_d  = bus.in_data;
          end
        end else if (out_fire_c) begin
          state_d = ST_EMPTY;
          main_d  = CLR_VAL;
        end
      end
      ST_TWO: begin
        if (out_fire_c) begin
          state_d = ST_ONE;
          main_d  = skid_q;
          skid_d  = CLR_VAL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        main_d  = CLR_VAL;
        skid_d  = CLR_VAL;
      end
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = CLR_VAL;
      skid_d  = CLR_VAL;
    end
    valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= CLR_VAL;
      skid_q  <= CLR_VAL;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
    end
  end

  // Saturating performance counters on pre-edge handshake values.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (valid_q && !bus.out_ready && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!valid_q && bus.out_ready && bubble_cnt != CNT_MAX)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (flush && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: instance a uses the skid buffer, instance b is pass-through with 4-bit counters.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic reset;
  logic flush_a, flush_b;
  logic [15:0] stall_a, bubble_a, fcnt_a;
  logic [3:0]  stall_b, bubble_b, fcnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW)) bus_a ();
  pipe_stage_reg_if #(.DATA_W(DW)) bus_b ();

  pipe_stage_reg #(.DATA_W(DW), .SKID(1'b1), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .flush(flush_a), .bus(bus_a),
    .stall_cnt(stall_a), .bubble_cnt(bubble_a), .flush_cnt(fcnt_a)
  );

  pipe_stage_reg #(.DATA_W(DW), .SKID(1'b0), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .flush(flush_b), .bus(bus_b),
    .stall_cnt(stall_b), .bubble_cnt(bubble_b), .flush_cnt(fcnt_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
    bus_a.in_valid = 1'b1; bus_a.in_data = 32'hAAAA_AAAA; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b1; bus_b.in_data = 32'hAAAA_AAAA; bus_b.out_ready = 1'b0;
    step(); step();
    check("rst_a_valid", bus_a.out_valid, 0);
    check("rst_a_data",  bus_a.out_data, 0);
    check("rst_a_ready", bus_a.in_ready, 1);
    check("rst_a_cnt",   {stall_a, bubble_a, fcnt_a}, 0);
    check("rst_b_valid", bus_b.out_valid, 0);
    check("rst_b_cnt",   {stall_b, bubble_b, fcnt_b}, 0);
    reset = 1'b0;
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;

    // Streaming 1..8 through the skid instance
    bus_a.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = DW'(i);
      step();
      check("stream_valid", bus_a.out_valid, 1);
      check("stream_data",  bus_a.out_data, 64'(i));
    end
    bus_a.in_valid = 1'b0;
    step();
    bus_a.out_ready = 1'b0;
    check("stream_drain", bus_a.out_valid, 0);
    check("stream_bubble", bubble_a, 1);
    check("stream_stall",  stall_a, 0);

    // Stall with skid capture
    bus_a.in_valid = 1'b1; bus_a.in_data = 32'd1;
    step();
    check("skid_d1", bus_a.out_data, 1);
    check("skid_rdy1", bus_a.in_ready, 1);
    bus_a.in_data = 32'd2;
    step();
    check("skid_rdy_low", bus_a.in_ready, 0);
    check("skid_hold1", bus_a.out_data, 1);
    bus_a.in_data = 32'd3;
    step(); step(); step();
    check("skid_stall4", stall_a, 4);
    check("skid_still1", bus_a.out_data, 1);
    bus_a.out_ready = 1'b1;
    step();
    check("skid_out2", bus_a.out_data, 2);
    check("skid_rdy_back", bus_a.in_ready, 1);
    step();
    check("skid_out3", bus_a.out_data, 3);
    check("skid_v3", bus_a.out_valid, 1);
    bus_a.in_valid = 1'b0;
    step();
    bus_a.out_ready = 1'b0;
    check("skid_empty", bus_a.out_valid, 0);
    check("skid_stall_final", stall_a, 4);
    check("skid_bubble", bubble_a, 1);

    // Flush while two entries are held
    bus_a.in_valid = 1'b1; bus_a.in_data = 32'd5;
    step();
    bus_a.in_data = 32'd6;
    step();
    check("fl_two", bus_a.in_ready, 0);
    flush_a = 1'b1; bus_a.in_data = 32'd7;
    step();
    flush_a = 1'b0; bus_a.in_valid = 1'b0;
    check("fl_valid", bus_a.out_valid, 0);
    check("fl_data",  bus_a.out_data, 0);
    check("fl_ready", bus_a.in_ready, 1);
    check("fl_cnt",   fcnt_a, 1);
    check("fl_stall", stall_a, 6);
    bus_a.out_ready = 1'b1;
    step();
    check("fl_no7", bus_a.out_valid, 0);
    check("fl_bubble", bubble_a, 2);
    bus_a.out_ready = 1'b0;

    // Reset beats a simultaneous flush
    reset = 1'b1; flush_a = 1'b1;
    step();
    reset = 1'b0; flush_a = 1'b0;
    check("rf_flush_cnt", fcnt_a, 0);
    check("rf_stall_cnt", stall_a, 0);
    check("rf_bubble_cnt", bubble_a, 0);

    // Pass-through mode: combinational ready
    bus_b.in_valid = 1'b1; bus_b.in_data = 32'h11;
    #1;
    check("b_rdy_empty", bus_b.in_ready, 1);
    step();
    check("b_v11", bus_b.out_valid, 1);
    check("b_d11", bus_b.out_data, 32'h11);
    check("b_rdy_full", bus_b.in_ready, 0);
    bus_b.in_data = 32'h22;
    bus_b.out_ready = 1'b1;
    #1;
    check("b_rdy_comb", bus_b.in_ready, 1);
    step();
    check("b_d22", bus_b.out_data, 32'h22);
    check("b_v22", bus_b.out_valid, 1);
    bus_b.in_valid = 1'b0;
    step();
    check("b_drain_v", bus_b.out_valid, 0);
    check("b_drain_d", bus_b.out_data, 0);
    check("b_stall", stall_b, 0);

    // Saturation of the 4-bit bubble counter
    for (int i = 0; i < 15; i++) step();
    check("b_bubble15", bubble_b, 15);
    for (int i = 0; i < 5; i++) step();
    check("b_bubble_sat", bubble_b, 15);
    check("b_flush_cnt", fcnt_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
